// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: MEM stage has priority, DMA/debug master gets single buffered bus cycles.
// Optional starvation guard enabled with `define DMEM_ARB_STARVE_EN.
module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int DMA_MAX_WAIT = 8
)(
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        cpu_mem_read,
  input  logic [1:0]        cpu_mem_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [1:0]        dma_size,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [1:0]        mem_read,
  output logic [1:0]        mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACC, RSP} state_t;

  state_t              state;
  logic                buf_we;
  logic [1:0]          buf_size;
  logic [ADDR_W-1:0]   buf_addr;
  logic [DATA_W-1:0]   buf_wdata;
  logic                cpu_idle;
  logic                starve;
  logic                grant;
  logic                grant_eval;

  // Out-of-range limits leave an empty marker block in the elaborated hierarchy.
  if (DMA_MAX_WAIT < 1 || DMA_MAX_WAIT > 255) begin : g_bad_dma_max_wait
  end

  assign cpu_idle   = (cpu_mem_read == 2'b00) && (cpu_mem_write == 2'b00);
  assign grant      = dma_req && (cpu_idle || starve);
  assign grant_eval = (state != ACC) && grant;

`ifdef DMEM_ARB_STARVE_EN
  localparam logic [7:0] MAX_WAIT = 8'(DMA_MAX_WAIT);
  logic [7:0] wait_cnt;

  assign starve = (wait_cnt >= MAX_WAIT);

  // Counts only bus-owned-by-CPU cycles where the DMA is kept waiting; holds through ACC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      wait_cnt <= '0;
    else if (!dma_req || grant_eval)
      wait_cnt <= '0;
    else if (state != ACC && wait_cnt != 8'hff)
      wait_cnt <= wait_cnt + 8'd1;
  end
`else
  assign starve = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      buf_we     <= 1'b0;
      buf_size   <= 2'b00;
      buf_addr   <= '0;
      buf_wdata  <= '0;
      dma_gnt    <= 1'b0;
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
    end else begin
      case (state)
        IDLE, RSP: begin
          dma_rvalid <= 1'b0;
          if (grant) begin
            state     <= ACC;
            buf_we    <= dma_we;
            buf_size  <= dma_size;
            buf_addr  <= dma_addr;
            buf_wdata <= dma_wdata;
            dma_gnt   <= 1'b1;
          end else begin
            state   <= IDLE;
            dma_gnt <= 1'b0;
          end
        end
        ACC: begin
          dma_gnt    <= 1'b0;
          dma_rvalid <= !buf_we;
          state      <= buf_we ? IDLE : RSP;
          if (!buf_we)
            dma_rdata <= mem_rdata;
        end
        default: begin
          state      <= IDLE;
          dma_gnt    <= 1'b0;
          dma_rvalid <= 1'b0;
        end
      endcase
    end
  end

  // A CPU access colliding with ACC is held off by the stall and reissued next cycle.
  always_comb begin
    mem_read  = cpu_mem_read;
    mem_write = cpu_mem_write;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    cpu_rdata = mem_rdata;
    cpu_stall = 1'b0;
    if (state == ACC) begin
      mem_read  = buf_we ? 2'b00 : buf_size;
      mem_write = buf_we ? buf_size : 2'b00;
      mem_addr  = buf_addr;
      mem_wdata = buf_wdata;
      cpu_rdata = '0;
      cpu_stall = !cpu_idle;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed steps then random traffic against a bus-slot reference model.
module tb_dmem_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXW = 8;
`ifdef DMEM_ARB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    cpu_mem_read, cpu_mem_write;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_stall;
  logic          dma_req, dma_we;
  logic [1:0]    dma_size;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata, dma_rdata;
  logic          dma_gnt, dma_rvalid;
  logic [1:0]    mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DMA_MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst),
    .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_size(dma_size), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Data memory device: combinational read, write on the rising edge.
  logic [DW-1:0] dev_mem [16] = '{default: '0};
  assign mem_rdata = dev_mem[mem_addr[3:0]];
  always @(posedge clk) if (mem_write != 2'b00) dev_mem[mem_addr[3:0]] <= mem_wdata;

  // Reference model: which master owns the bus slot this cycle, the accepted request, shadow memory.
  bit            m_owned, m_rsp, m_we, prev_owned;
  logic [1:0]    m_size;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  int            m_wait;
  logic [DW-1:0] ref_mem [16];
  logic [1:0]    x_wr;
  logic [AW-1:0] x_addr;
  logic [DW-1:0] x_wd;

  int errors = 0;
  int checks = 0;
  int first;
  logic stall_at;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owned = 0; m_rsp = 0; m_rdata = '0; m_wait = 0; prev_owned = 0; x_wr = 2'b00;
  endtask

  task automatic set_cpu(input logic [1:0] rd, input logic [1:0] wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_mem_read = rd; cpu_mem_write = wr; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_dma(input logic req, input logic we, input logic [1:0] sz, input logic [AW-1:0] a, input logic [DW-1:0] d);
    dma_req = req; dma_we = we; dma_size = sz; dma_addr = a; dma_wdata = d;
  endtask

  task automatic sample(input string tag);
    logic idle, eg, es, erv;
    logic [1:0] erd, ewr;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd, ecrd;
    #1;
    idle = (cpu_mem_read == 2'b00) && (cpu_mem_write == 2'b00);
    if (m_owned) begin
      erd = m_we ? 2'b00 : m_size; ewr = m_we ? m_size : 2'b00;
      ea = m_addr; ewd = m_wdata; ecrd = '0; eg = 1'b1; es = !idle; erv = 1'b0;
    end else begin
      erd = cpu_mem_read; ewr = cpu_mem_write; ea = cpu_addr; ewd = cpu_wdata;
      ecrd = ref_mem[cpu_addr[3:0]]; eg = 1'b0; es = 1'b0; erv = m_rsp;
    end
    chk({tag, ".mem_read"},   32'(mem_read),   32'(erd));
    chk({tag, ".mem_write"},  32'(mem_write),  32'(ewr));
    chk({tag, ".mem_addr"},   mem_addr,        ea);
    chk({tag, ".mem_wdata"},  mem_wdata,       ewd);
    chk({tag, ".cpu_rdata"},  cpu_rdata,       ecrd);
    chk({tag, ".cpu_stall"},  32'(cpu_stall),  32'(es));
    chk({tag, ".dma_gnt"},    32'(dma_gnt),    32'(eg));
    chk({tag, ".dma_rvalid"}, 32'(dma_rvalid), 32'(erv));
    chk({tag, ".dma_rdata"},  dma_rdata,       m_rdata);
    x_wr = ewr; x_addr = ea; x_wd = ewd;
  endtask

  task automatic tick();
    logic idle, g;
    if (x_wr != 2'b00) ref_mem[x_addr[3:0]] = x_wd;
    prev_owned = m_owned;
    if (m_owned) begin
      m_owned = 0;
      m_rsp   = !m_we;
      if (!m_we) m_rdata = ref_mem[m_addr[3:0]];
      m_wait  = 0;
    end else begin
      idle  = (cpu_mem_read == 2'b00) && (cpu_mem_write == 2'b00);
      g     = dma_req && (idle || (STARVE_ON && m_wait >= MAXW));
      m_rsp = 0;
      if (g) begin
        m_owned = 1; m_we = dma_we; m_size = dma_size; m_addr = dma_addr; m_wdata = dma_wdata;
        m_wait = 0;
      end else if (dma_req) m_wait = (m_wait < 255) ? m_wait + 1 : 255;
      else m_wait = 0;
    end
    x_wr = 2'b00;
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    rst = 1'b0;
    set_cpu(2'b01, 2'b00, 5, 0);
    set_dma(0, 0, 2'b00, 0, 0);
    model_reset();
    @(posedge clk); #1;
    #1;
    chk("rst.dma_gnt",    32'(dma_gnt),    0);
    chk("rst.dma_rvalid", 32'(dma_rvalid), 0);
    chk("rst.dma_rdata",  dma_rdata,       0);
    chk("rst.cpu_stall",  32'(cpu_stall),  0);
    chk("rst.mem_read",   32'(mem_read),   1);
    rst = 1'b1;

    sample("pass");
    chk("pass.lw_read", 32'(mem_read), 1);
    chk("pass.lw_addr", mem_addr, 5);
    tick();

    set_cpu(2'b00, 2'b01, 12, 32'hDEADBEEF); sample("st12"); tick();
    set_cpu(2'b00, 2'b01, 4, 32'h000000A5);  sample("st4");  tick();
    set_cpu(2'b00, 2'b00, 0, 0);

    // Uncontended DMA write
    set_dma(1, 1, 2'b01, 8, 32'h00001234);
    sample("dw.req"); chk("dw.req_gnt", 32'(dma_gnt), 0); tick();
    sample("dw.acc");
    chk("dw.gnt", 32'(dma_gnt), 1);
    chk("dw.mem_write", 32'(mem_write), 1);
    chk("dw.mem_addr", mem_addr, 8);
    chk("dw.mem_wdata", mem_wdata, 32'h00001234);
    tick();
    dma_req = 0;
    sample("dw.after");
    chk("dw.after_write", 32'(mem_write), 0);
    chk("dw.no_rvalid", 32'(dma_rvalid), 0);
    tick();

    // Uncontended DMA read
    set_dma(1, 0, 2'b01, 12, 0);
    sample("dr.req"); tick();
    sample("dr.acc"); chk("dr.gnt", 32'(dma_gnt), 1); chk("dr.mem_read", 32'(mem_read), 1); tick();
    dma_req = 0;
    sample("dr.rsp");
    chk("dr.rvalid", 32'(dma_rvalid), 1);
    chk("dr.rdata", dma_rdata, 32'hDEADBEEF);
    tick();
    sample("dr.hold");
    chk("dr.rvalid_off", 32'(dma_rvalid), 0);
    chk("dr.rdata_hold", dma_rdata, 32'hDEADBEEF);
    tick();

    // CPU store collides with the ACC cycle
    set_dma(1, 0, 2'b01, 3, 0);
    sample("col.req"); tick();
    set_cpu(2'b00, 2'b01, 2, 7);
    sample("col.acc");
    chk("col.stall", 32'(cpu_stall), 1);
    chk("col.addr", mem_addr, 3);
    chk("col.write_blocked", 32'(mem_write), 0);
    tick();
    dma_req = 0;
    sample("col.retry");
    chk("col.retry_stall", 32'(cpu_stall), 0);
    chk("col.retry_write", 32'(mem_write), 1);
    chk("col.retry_addr", mem_addr, 2);
    chk("col.retry_data", mem_wdata, 7);
    tick();
    set_cpu(2'b00, 2'b00, 0, 0);

    // Reset asserted during a DMA write ACC
    set_dma(1, 1, 2'b01, 4, 32'h55);
    sample("rm.req"); tick();
    sample("rm.acc"); chk("rm.acc_write", 32'(mem_write), 1);
    rst = 1'b0; #1;
    chk("rm.write_dropped", 32'(mem_write), 0);
    chk("rm.gnt_dropped", 32'(dma_gnt), 0);
    model_reset();
    dma_req = 0;
    @(posedge clk); #1;
    chk("rm.no_rvalid", 32'(dma_rvalid), 0);
    rst = 1'b1;
    set_cpu(2'b01, 2'b00, 4, 0);
    sample("rm.rd4"); chk("rm.mem_kept", cpu_rdata, 32'h000000A5); tick();

    // Starvation: CPU loads every cycle while the DMA read is held
    set_dma(1, 0, 2'b01, 9, 0);
    first = -1; stall_at = 1'b0;
    for (int i = 0; i < 50; i++) begin
      sample("sv");
      if (dma_gnt && first < 0) begin first = i; stall_at = cpu_stall; end
      tick();
      if (first >= 0) dma_req = 0;
    end
`ifdef DMEM_ARB_STARVE_EN
    chk("sv.first_gnt", 32'(first), 9);
    chk("sv.gnt_stall", 32'(stall_at), 1);
`else
    chk("sv.no_gnt", 32'(first), 32'hFFFFFFFF);
    set_cpu(2'b00, 2'b00, 0, 0);
    sample("sv.idle"); chk("sv.idle_gnt", 32'(dma_gnt), 0); tick();
    sample("sv.gnt");  chk("sv.late_gnt", 32'(dma_gnt), 1); tick();
    dma_req = 0;
    sample("sv.rsp"); chk("sv.rsp_rvalid", 32'(dma_rvalid), 1); tick();
`endif
    set_cpu(2'b00, 2'b00, 0, 0); dma_req = 0;
    sample("sv.end"); tick();

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 4)      set_cpu(2'b00, 2'b00, $urandom_range(0, 15), $urandom);
      else if (r < 7) set_cpu(2'($urandom_range(1, 3)), 2'b00, $urandom_range(0, 15), $urandom);
      else if (r < 9) set_cpu(2'b00, 2'($urandom_range(1, 3)), $urandom_range(0, 15), $urandom);
      else            set_cpu(2'($urandom_range(1, 3)), 2'($urandom_range(1, 3)), $urandom_range(0, 15), $urandom);
      if (dma_req && prev_owned) dma_req = 0;
      if (!dma_req) begin
        if ($urandom_range(0, 3) == 0)
          set_dma(1, 1'($urandom_range(0, 1)), 2'($urandom_range(1, 2)), $urandom_range(0, 15), $urandom);
      end else if (!m_owned && $urandom_range(0, 19) == 0) dma_req = 0;
      sample("rnd");
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
